clk_div_cfg_ctrl: RTL and testbench
===================================

// Module: clk_div_cfg_ctrl
// PURPOSE
//  Owns the clock divider's control inputs (enable, 4-bit ratio) and shares them among NUM_REQ requesters.
//  Requesters are, e.g., UART prescale or baud-select logic.
//  Round-robin arbitration; each ratio change is sequenced glitch-free: disable -> settle -> load -> enable -> lock wait -> ack.
//  Sits in the i_ref_clk domain, directly in front of the divider.
// PARAMETERS
//  NUM_REQ     2  number of requesters (>=1)
//  RATIO_W     4  width of the divide ratio; matches the divider's ratio input
//  SETTLE_CYC  2  cycles the divider is held disabled before the ratio changes (>=1)
//  RST_RATIO   2  o_div_ratio value after reset
// PORTS
//  i_ref_clk    in   1                clock; same clock as the divider
//  i_rst        in   1                synchronous reset, active-high
//  i_global_en  in   1                master enable for the divided clock
//  i_req        in   NUM_REQ          level request per requester; held until its o_ack
//  i_req_ratio  in   NUM_REQ*RATIO_W  requested ratio, requester k at [k*RATIO_W +: RATIO_W]
//  o_ack        out  NUM_REQ          one-cycle completion pulse to the granted requester
//  o_busy       out  1                high whenever the FSM is not IDLE
//  o_grant_id   out  $clog2(NUM_REQ)  id of the current/last granted requester (0 when NUM_REQ=1)
//  o_clk_en     out  1                to divider enable
//  o_div_ratio  out  RATIO_W          to divider ratio
// BEHAVIOUR
//  Reset: o_clk_en=0, o_div_ratio=RST_RATIO, o_ack=0, o_busy=0, o_grant_id=0, rr pointer=0, state=IDLE.
//  All outputs are registered.
//  FSM states: IDLE, DRAIN, LOAD, ENABLE, WAIT_LOCK, ACK.
//  IDLE:
//   - o_clk_en <= i_global_en & cfg_valid. cfg_valid is set at the first ACK and cleared only by reset.
//   - Arbitration runs only when i_global_en=1 and at least one i_req bit is set.
//   - Round-robin grant: search starts at pointer; pointer <= granted id+1, wrapping at NUM_REQ.
//   - On grant: latch the granted ratio and id.
//   - Fast path: latched ratio == o_div_ratio and o_clk_en=1 -> go straight to ACK (ack at T+1; divider untouched).
//   - Otherwise: o_clk_en <= 0, go to DRAIN, cnt <= SETTLE_CYC.
//  DRAIN: decrement cnt; at cnt==1 go to LOAD. o_clk_en stays 0.
//  LOAD: o_div_ratio <= latched ratio; go to ENABLE.
//  ENABLE:
//   - o_clk_en <= 1; cnt <= LOCK.
//   - LOCK = 2*ratio for ratio>=2, else 1. cnt is RATIO_W+1 bits (ratio 15 -> 30).
//   - Go to WAIT_LOCK.
//  WAIT_LOCK: decrement cnt; at cnt==1 go to ACK.
//  ACK: o_ack[id]=1 for exactly this cycle; go to IDLE. The new request is evaluated no earlier than the next cycle.
//  Latency: req seen in IDLE at cycle T -> o_ack at T+SETTLE_CYC+3+LOCK; o_clk_en low during T+1..T+SETTLE_CYC+2.
//  Ratios 0 and 1 are legal (divider bypass); sequenced the same way, LOCK=1.
//  i_global_en is sampled only in IDLE. A transaction in progress always completes, including its o_clk_en=1.
//   If i_global_en is low at the return to IDLE, o_clk_en <= 0 the following cycle.
//  Requester drops i_req before its ack: protocol error; the transaction still completes and acks that id.
//  A request held through ACK is re-arbitrated in IDLE; the fast path acks it if the ratio is unchanged.
//  Simultaneous requests: one grant per transaction; losers wait, with no starvation beyond NUM_REQ-1 transactions.
//  Reset mid-transaction: everything returns to reset values next cycle; no ack issued.
// STRUCTURE
//  Package clk_div_ctrl_pkg:
//   - state enum (IDLE..ACK)
//   - function lock_cycles(ratio)
//   - RATIO_W default constant
//  Sub-module rr_arbiter #(NUM_REQ): i_req, i_ptr -> o_grant_vld, o_grant_id (combinational).
//  Pointer register and FSM live in the top module.
// TESTING
//  1. Reset, then req[0] with ratio 4 at T, global_en=1:
//     o_clk_en=0 T+1..T+4, o_div_ratio=4 from T+4, o_clk_en=1 from T+5, o_ack[0] at T+13.
//  2. req[0] and req[1] both high, ratios 3 and 6, pointer=0:
//     ack[0] first (ratio 3), then ack[1] (ratio 6); a third round with both high grants 0 again.
//  3. Repeat req[0] with ratio 4 after test 1: o_ack[0] at T+1, o_clk_en stays 1, o_div_ratio stays 4.
//  4. Request ratio 15: LOCK=30, o_ack at T+35; ratio 0: LOCK=1, o_ack at T+6.
//  5. Assert i_rst during WAIT_LOCK: next cycle o_clk_en=0, o_div_ratio=2, o_busy=0, no o_ack pulse.
//  6. Drop i_global_en during DRAIN: transaction completes with its ack; o_clk_en=0 one cycle after the return to IDLE.
//     With global_en low, no new grant is issued.

Source files
------------

// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and helpers for the clock-divider configuration controller.
package clk_div_ctrl_pkg;

    localparam int unsigned DEF_RATIO_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        LOAD,
        ENABLE,
        WAIT_LOCK,
        ACK
    } state_t;

    // Cycles the divider needs after re-enable before its output is trusted.
    function automatic int unsigned lock_cycles(input int unsigned ratio);
        return (ratio >= 2) ? 2 * ratio : 1;
    endfunction

endpackage

// File: rtl/clk_div_cfg_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after i_ptr wins.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic               o_grant_vld,
    output logic [ID_W-1:0]    o_grant_id
);

    int unsigned idx;

    always_comb begin
        o_grant_vld = 1'b0;
        o_grant_id  = '0;
        idx         = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(i_ptr) + i) % NUM_REQ;
            if (!o_grant_vld && i_req[ID_W'(idx)]) begin
                o_grant_vld = 1'b1;
                o_grant_id  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Arbitrates divider ratio changes among requesters and sequences each change glitch-free.
module clk_div_cfg_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned RATIO_W    = DEF_RATIO_W,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned RST_RATIO  = 2,
    parameter int unsigned ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       i_ref_clk,
    input  logic                       i_rst,
    input  logic                       i_global_en,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ*RATIO_W-1:0] i_req_ratio,
    output logic [NUM_REQ-1:0]         o_ack,
    output logic                       o_busy,
    output logic [ID_W-1:0]            o_grant_id,
    output logic                       o_clk_en,
    output logic [RATIO_W-1:0]         o_div_ratio
);

    localparam int unsigned CNT_W = RATIO_W + 1;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [RATIO_W-1:0]   ratio_q, ratio_d;
    logic [RATIO_W-1:0]   div_ratio_q, div_ratio_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 clk_en_q, clk_en_d;
    logic                 cfg_valid_q, cfg_valid_d;
    logic                 busy_q, busy_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;

    logic                 arb_vld;
    logic [ID_W-1:0]      arb_id;
    logic [RATIO_W-1:0]   ratio_arr [NUM_REQ];
    logic [RATIO_W-1:0]   arb_ratio;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_ratio
        assign ratio_arr[k] = i_req_ratio[k*RATIO_W +: RATIO_W];
    end

    assign arb_ratio = ratio_arr[arb_id];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req       (i_req),
        .i_ptr       (ptr_q),
        .o_grant_vld (arb_vld),
        .o_grant_id  (arb_id)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        ratio_d     = ratio_q;
        div_ratio_d = div_ratio_q;
        cnt_d       = cnt_q;
        clk_en_d    = clk_en_q;
        cfg_valid_d = cfg_valid_q;
        ack_d       = '0;

        case (state_q)
            IDLE: begin
                clk_en_d = i_global_en & cfg_valid_q;
                if (i_global_en && arb_vld) begin
                    id_d    = arb_id;
                    ratio_d = arb_ratio;
                    ptr_d   = (32'(arb_id) == NUM_REQ - 1) ? '0 : ID_W'(32'(arb_id) + 1);
                    // Unchanged ratio on a running divider needs no resequencing.
                    if (arb_ratio == div_ratio_q && clk_en_q) begin
                        state_d       = ACK;
                        ack_d[arb_id] = 1'b1;
                    end else begin
                        clk_en_d = 1'b0;
                        cnt_d    = CNT_W'(SETTLE_CYC);
                        state_d  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = LOAD;
            end
            LOAD: begin
                div_ratio_d = ratio_q;
                state_d     = ENABLE;
            end
            ENABLE: begin
                clk_en_d = 1'b1;
                cnt_d    = CNT_W'(lock_cycles(32'(ratio_q)));
                state_d  = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = ACK;
                    ack_d[id_q] = 1'b1;
                end
            end
            ACK: begin
                cfg_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            ratio_q     <= RATIO_W'(RST_RATIO);
            div_ratio_q <= RATIO_W'(RST_RATIO);
            cnt_q       <= '0;
            clk_en_q    <= 1'b0;
            cfg_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ack_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            ratio_q     <= ratio_d;
            div_ratio_q <= div_ratio_d;
            cnt_q       <= cnt_d;
            clk_en_q    <= clk_en_d;
            cfg_valid_q <= cfg_valid_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
        end
    end

    assign o_ack       = ack_q;
    assign o_busy      = busy_q;
    assign o_grant_id  = id_q;
    assign o_clk_en    = clk_en_q;
    assign o_div_ratio = div_ratio_q;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Self-checking bench for clk_div_cfg_ctrl: vector table plus hand-written corner sequences.
module tb_clk_div_cfg_ctrl;

    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       gen;
    logic [1:0] req;
    logic [7:0] req_ratio;
    logic [1:0] ack;
    logic       busy;
    logic [0:0] grant_id;
    logic       clk_en;
    logic [3:0] div_ratio;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int       id;
        int       cyc;
        logic [3:0] ratio;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [1:0] mask;
        logic [3:0] ratio;
        int         exp_id;
        int         exp_lat;
        logic       fast;
    } vec_t;
    vec_t vecs[7];

    clk_div_cfg_ctrl dut (
        .i_ref_clk   (clk),
        .i_rst       (rst),
        .i_global_en (gen),
        .i_req       (req),
        .i_req_ratio (req_ratio),
        .o_ack       (ack),
        .o_busy      (busy),
        .o_grant_id  (grant_id),
        .o_clk_en    (clk_en),
        .o_div_ratio (div_ratio)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every ack must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (!rst && ack != 2'b00) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_ack: got ack=%b at cycle %0d, required none", ack, cyc);
            end else begin
                exp_t e;
                logic [1:0] e_ack;
                e = exp_q.pop_front();
                e_ack = 2'(1 << e.id);
                if (ack != e_ack || cyc != e.cyc || div_ratio != e.ratio ||
                    !clk_en || 32'(grant_id) != e.id) begin
                    n_err++;
                    $display("FAIL ack_check: got ack=%b cyc=%0d ratio=%0d clk_en=%b gid=%0d, required ack=%b cyc=%0d ratio=%0d clk_en=1 gid=%0d",
                             ack, cyc, div_ratio, clk_en, grant_id, e_ack, e.cyc, e.ratio, e.id);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold requests until acked; each ack drops its requester's level.
    task automatic wait_acks(input string name, input int budget);
        int c;
        c = 0;
        while (req != 2'b00 && c < budget) begin
            step();
            c++;
            req = req & ~ack;
        end
        chk({name, "_timeout"}, int'(req), 0);
        req = 2'b00;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int start;
        int c;
        start = cyc;
        exp_q.push_back('{v.exp_id, start + v.exp_lat, v.ratio});
        req_ratio = (v.mask == 2'b01) ? {4'd9, v.ratio} : {v.ratio, 4'd9};
        req = v.mask;
        c = 0;
        while (req != 2'b00 && c < v.exp_lat + 3) begin
            step();
            c++;
            if (c == 1) chk($sformatf("v%0d_busy", n), int'(busy), 1);
            if (v.fast && c == 1) chk($sformatf("v%0d_fast_en", n), int'(clk_en), 1);
            if (!v.fast && c == SETTLE + 2) begin
                chk($sformatf("v%0d_en_low", n), int'(clk_en), 0);
                chk($sformatf("v%0d_ratio_load", n), int'(div_ratio), int'(v.ratio));
            end
            if (!v.fast && c == SETTLE + 3) chk($sformatf("v%0d_en_high", n), int'(clk_en), 1);
            req = req & ~ack;
        end
        chk($sformatf("v%0d_timeout", n), int'(req), 0);
        req = 2'b00;
        step();
    endtask

    initial begin
        int start;
        vecs[0] = '{2'b01, 4'd4,  0, 13, 1'b0};
        vecs[1] = '{2'b01, 4'd4,  0, 1,  1'b1};
        vecs[2] = '{2'b10, 4'd15, 1, 35, 1'b0};
        vecs[3] = '{2'b01, 4'd0,  0, 6,  1'b0};
        vecs[4] = '{2'b01, 4'd1,  0, 6,  1'b0};
        vecs[5] = '{2'b10, 4'd1,  1, 1,  1'b1};
        vecs[6] = '{2'b10, 4'd2,  1, 9,  1'b0};

        rst = 1'b1; gen = 1'b1; req = 2'b00; req_ratio = 8'h00;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_clk_en", int'(clk_en), 0);
        chk("rst_ratio", int'(div_ratio), 2);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_gid", int'(grant_id), 0);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Contention, pointer at 0: id0 then id1; second round grants id0 again.
        for (int round = 0; round < 2; round++) begin
            start = cyc;
            exp_q.push_back('{0, start + 11, 4'd3});
            exp_q.push_back('{1, start + 29, 4'd6});
            req_ratio = {4'd6, 4'd3};
            req = 2'b11;
            wait_acks($sformatf("both_r%0d", round), 40);
            step();
        end

        // Reset in WAIT_LOCK: outputs return to reset values, no ack.
        req_ratio = {4'd9, 4'd8};
        req = 2'b01;
        repeat (6) step();
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        step();
        chk("midrst_clk_en", int'(clk_en), 0);
        chk("midrst_ratio", int'(div_ratio), 2);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ack", int'(ack), 0);
        req = 2'b00;
        step();
        rst = 1'b0;
        repeat (25) step();
        chk("midrst_no_ack_pending", exp_q.size(), 0);

        // Global enable dropped in DRAIN: the transaction still completes.
        start = cyc;
        exp_q.push_back('{0, start + 15, 4'd5});
        req_ratio = {4'd9, 4'd5};
        req = 2'b01;
        step();
        gen = 1'b0;
        wait_acks("gen_drop", 20);
        step();
        chk("gen_drop_idle_en", int'(clk_en), 1);
        step();
        chk("gen_drop_en_off", int'(clk_en), 0);
        req_ratio = {4'd7, 4'd5};
        req = 2'b10;
        begin
            int busy_seen;
            busy_seen = 0;
            repeat (10) begin
                step();
                busy_seen = busy_seen | int'(busy);
            end
            chk("gen_low_no_grant", busy_seen, 0);
        end
        chk("gen_low_gid", int'(grant_id), 0);
        req = 2'b00;
        repeat (3) step();
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
